// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stages: MEM FSM state,
// writeback control field layout and the abort data pattern.
package pipe_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  localparam int WB_W        = 2;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Clear/enable access-cycle counter for the MEM stage; saturates at TIMEOUT
// and flags the last allowed cycle (count == TIMEOUT-1).
module mem_timeout_ctr #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == CNT_LAST);

endmodule

// File: rtl/mem_stage.sv
// MEM stage: branch/jump resolution, data-memory access over a req/ack bus
// with upstream stall and timeout abort, and the MEM/WB result registers.
module mem_stage
  import pipe_pkg::*;
#(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic            clkMEM,
  input  logic            rstMEM_n,
  input  logic [WB_W-1:0] Wb2,
  input  logic            Branch,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic [31:0]     tMux32,
  input  logic            ZFtAND,
  input  logic [31:0]     AluRes,
  input  logic [31:0]     tWriteData,
  input  logic [4:0]      toMEMWB,
  input  logic            jump_out,
  output logic            PCSrc,
  output logic [31:0]     PCTarget,
  output logic            stall,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [31:0]     dmem_addr,
  output logic [31:0]     dmem_wdata,
  input  logic [31:0]     dmem_rdata,
  input  logic            dmem_ack,
  output logic [WB_W-1:0] Wb3,
  output logic [31:0]     ReadData,
  output logic [31:0]     AluResOut,
  output logic [4:0]      rdOut,
  output logic            mem_err
);

  mem_state_t      state_q, state_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            load_q, load_d;
  logic [WB_W-1:0] wbc_q, wbc_d;
  logic [4:0]      rdc_q, rdc_d;
  logic [WB_W-1:0] wb3_q, wb3_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [31:0]     alu_q, alu_d;
  logic [4:0]      rdout_q, rdout_d;
  logic            err_q, err_d;

  logic ctr_clr, ctr_en, ctr_tc;
  logic stall_c;
  logic is_mem, is_illegal;

  assign PCSrc    = (Branch & ZFtAND) | jump_out;
  assign PCTarget = tMux32;

  assign is_mem     = MemRead | MemWrite;
  assign is_illegal = (MemRead & MemWrite) | (is_mem & ~is_word_aligned(AluRes));

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
    .clk   (clkMEM),
    .rst_n (rstMEM_n),
    .clr   (ctr_clr),
    .en    (ctr_en),
    .tc    (ctr_tc)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    load_d  = load_q;
    wbc_d   = wbc_q;
    rdc_d   = rdc_q;
    wb3_d   = wb3_q;
    rdata_d = rdata_q;
    alu_d   = alu_q;
    rdout_d = rdout_q;
    err_d   = err_q;
    ctr_clr = 1'b0;
    ctr_en  = 1'b0;
    stall_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_illegal) begin
          wb3_d   = '0;
          err_d   = 1'b1;
          rdata_d = '0;
          alu_d   = AluRes;
          rdout_d = toMEMWB;
        end else if (is_mem) begin
          // Capture everything the access and its writeback need; upstream
          // holds its inputs while stalled, but nothing here depends on it.
          stall_c = 1'b1;
          we_d    = MemWrite;
          load_d  = MemRead;
          addr_d  = {AluRes[31:2], 2'b00};
          wdata_d = tWriteData;
          wbc_d   = Wb2;
          rdc_d   = toMEMWB;
          ctr_clr = 1'b1;
          wb3_d   = '0;
          err_d   = 1'b0;
          state_d = ACCESS;
        end else begin
          wb3_d   = Wb2;
          err_d   = 1'b0;
          rdata_d = '0;
          alu_d   = AluRes;
          rdout_d = toMEMWB;
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          wb3_d   = wbc_q;
          rdata_d = load_q ? dmem_rdata : 32'h0;
          alu_d   = addr_q;
          rdout_d = rdc_q;
          err_d   = 1'b0;
          state_d = IDLE;
        end else if (ctr_tc) begin
          wb3_d   = '0;
          rdata_d = ERR_DATA;
          alu_d   = addr_q;
          rdout_d = rdc_q;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          stall_c = 1'b1;
          ctr_en  = 1'b1;
          wb3_d   = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkMEM or negedge rstMEM_n) begin
    if (!rstMEM_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      load_q  <= 1'b0;
      wbc_q   <= '0;
      rdc_q   <= '0;
      wb3_q   <= '0;
      rdata_q <= '0;
      alu_q   <= '0;
      rdout_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      load_q  <= load_d;
      wbc_q   <= wbc_d;
      rdc_q   <= rdc_d;
      wb3_q   <= wb3_d;
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      rdout_q <= rdout_d;
      err_q   <= err_d;
    end
  end

  // Stall is masked during reset so upstream is never frozen by a held load.
  assign stall      = stall_c & rstMEM_n;
  assign dmem_req   = (state_q == ACCESS);
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign Wb3        = wb3_q;
  assign ReadData   = rdata_q;
  assign AluResOut  = alu_q;
  assign rdOut      = rdout_q;
  assign mem_err    = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ops push expected MEM/WB results,
// a monitor compares them on each retiring edge and checks bubbles.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  Wb2;
  logic        Branch, MemRead, MemWrite, ZFtAND, jump_out;
  logic [31:0] tMux32, AluRes, tWriteData;
  logic [4:0]  toMEMWB;
  logic        PCSrc, stall, dmem_req, dmem_we, mem_err;
  logic [31:0] PCTarget, dmem_addr, dmem_wdata, ReadData, AluResOut;
  logic [31:0] dmem_rdata = 32'h0;
  logic        dmem_ack = 1'b0;
  logic [1:0]  Wb3;
  logic [4:0]  rdOut;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(16), .ERR_DATA(32'hDEADBEEF)) dut (
    .clkMEM(clk), .rstMEM_n(rst_n), .Wb2(Wb2), .Branch(Branch),
    .MemRead(MemRead), .MemWrite(MemWrite), .tMux32(tMux32), .ZFtAND(ZFtAND),
    .AluRes(AluRes), .tWriteData(tWriteData), .toMEMWB(toMEMWB),
    .jump_out(jump_out), .PCSrc(PCSrc), .PCTarget(PCTarget), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .Wb3(Wb3), .ReadData(ReadData), .AluResOut(AluResOut), .rdOut(rdOut),
    .mem_err(mem_err)
  );

  typedef struct {
    logic [1:0]  wb;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        err;
    bit          chk_ar;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Bus responder: ack in ACCESS cycle number ack_at (0 = never), plus an
  // optional stray ack injected by the sequence.
  int          ack_at = 0;
  int          acc_cyc = 0;
  logic [31:0] rdata_val = 32'h0;
  logic        stray_ack = 1'b0;

  always @(posedge clk) begin
    #3;
    if (dmem_req) begin
      acc_cyc++;
      dmem_ack = (acc_cyc == ack_at) || stray_ack;
    end else begin
      acc_cyc  = 0;
      dmem_ack = stray_ack;
    end
    dmem_rdata = rdata_val;
  end

  logic mon_en = 1'b0;
  logic mon_s, mon_e;
  exp_t mon_x;

  initial begin
    forever begin
      @(negedge clk);
      mon_s = stall;
      mon_e = mon_en;
      @(posedge clk);
      #1;
      if (mon_e) begin
        if (!mon_s) begin
          if (sbq.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL retire_unexpected: got a retiring edge, expected none");
          end else begin
            mon_x = sbq.pop_front();
            check("wb3", 32'(Wb3), 32'(mon_x.wb));
            check("readdata", ReadData, mon_x.rdata);
            check("mem_err", 32'(mem_err), 32'(mon_x.err));
            if (mon_x.chk_ar) begin
              check("aluresout", AluResOut, mon_x.alu);
              check("rdout", 32'(rdOut), 32'(mon_x.rd));
            end
          end
        end else begin
          check("bubble_wb3", 32'(Wb3), 32'h0);
          check("bubble_err", 32'(mem_err), 32'h0);
        end
      end
    end
  end

  int          g_stalls;
  bit          g_saw;
  logic [31:0] g_addr, g_wdata;
  logic        g_we;

  task automatic set_op(input logic [1:0] wb, input logic mr, input logic mw,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd);
    Wb2 = wb; MemRead = mr; MemWrite = mw; AluRes = alu; tWriteData = wd;
    toMEMWB = rd; Branch = 1'b0; ZFtAND = 1'b0; jump_out = 1'b0; tMux32 = 32'h0;
  endtask

  // Issue the op on the inputs, wait (bounded) for it to retire.
  task automatic go(input exp_t e);
    int n;
    sbq.push_back(e);
    g_stalls = 0; g_saw = 0; g_addr = '0; g_wdata = '0; g_we = 1'b0;
    n = 0;
    @(negedge clk);
    while (stall && n < 40) begin
      if (dmem_req) begin
        g_saw = 1; g_addr = dmem_addr; g_wdata = dmem_wdata; g_we = dmem_we;
      end
      g_stalls++;
      n++;
      @(negedge clk);
    end
    if (dmem_req) begin
      g_saw = 1; g_addr = dmem_addr; g_wdata = dmem_wdata; g_we = dmem_we;
    end
    if (stall) begin
      n_vec++;
      n_bad++;
      $display("FAIL go_timeout: stall still 1 after %0d cycles, expected release", n);
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    set_op(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    check("rst_wb3", 32'(Wb3), 32'h0);
    check("rst_readdata", ReadData, 32'h0);
    check("rst_aluresout", AluResOut, 32'h0);
    check("rst_rdout", 32'(rdOut), 32'h0);
    check("rst_mem_err", 32'(mem_err), 32'h0);
    check("rst_req", 32'(dmem_req), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    mon_en = 1'b1;

    set_op(2'b10, 1'b0, 1'b0, 32'h0000_0042, 32'h0, 5'd9);
    go('{2'b10, 32'h0, 32'h42, 5'd9, 1'b0, 1'b1});
    check("alu_stalls", 32'(g_stalls), 32'd0);

    set_op(2'b00, 1'b0, 1'b0, 32'h11, 32'h0, 5'd2);
    Branch = 1'b1; ZFtAND = 1'b1; tMux32 = 32'h40;
    #1;
    check("br_taken_pcsrc", 32'(PCSrc), 32'h1);
    check("br_taken_target", PCTarget, 32'h40);
    go('{2'b00, 32'h0, 32'h11, 5'd2, 1'b0, 1'b1});

    set_op(2'b10, 1'b0, 1'b0, 32'h22, 32'h0, 5'd3);
    Branch = 1'b1; ZFtAND = 1'b0; tMux32 = 32'h80;
    #1;
    check("br_nottaken_pcsrc", 32'(PCSrc), 32'h0);
    go('{2'b10, 32'h0, 32'h22, 5'd3, 1'b0, 1'b1});

    ack_at = 3; rdata_val = 32'hCAFEF00D;
    set_op(2'b11, 1'b1, 1'b0, 32'h100, 32'h0, 5'd5);
    go('{2'b11, 32'hCAFEF00D, 32'h100, 5'd5, 1'b0, 1'b1});
    check("load_stalls", 32'(g_stalls), 32'd3);
    check("load_req_seen", 32'(g_saw), 32'h1);
    check("load_addr", g_addr, 32'h100);
    check("load_we", 32'(g_we), 32'h0);

    ack_at = 1; rdata_val = 32'h5555_5555;
    set_op(2'b00, 1'b0, 1'b1, 32'h204, 32'h1234, 5'd0);
    go('{2'b00, 32'h0, 32'h204, 5'd0, 1'b0, 1'b1});
    check("store_stalls", 32'(g_stalls), 32'd1);
    check("store_we", 32'(g_we), 32'h1);
    check("store_wdata", g_wdata, 32'h1234);
    check("store_addr", g_addr, 32'h204);

    set_op(2'b11, 1'b1, 1'b0, 32'h103, 32'h0, 5'd7);
    go('{2'b00, 32'h0, 32'h103, 5'd7, 1'b1, 1'b1});
    check("misalign_stalls", 32'(g_stalls), 32'd0);
    check("misalign_req", 32'(g_saw), 32'h0);

    set_op(2'b10, 1'b1, 1'b1, 32'h200, 32'h0, 5'd8);
    go('{2'b00, 32'h0, 32'h200, 5'd8, 1'b1, 1'b1});
    check("rw_stalls", 32'(g_stalls), 32'd0);
    check("rw_req", 32'(g_saw), 32'h0);

    ack_at = 0;
    set_op(2'b11, 1'b1, 1'b0, 32'h300, 32'h0, 5'd3);
    go('{2'b00, 32'hDEADBEEF, 32'h0, 5'd0, 1'b1, 1'b0});
    check("timeout_stalls", 32'(g_stalls), 32'd16);

    set_op(2'b01, 1'b0, 1'b0, 32'h55, 32'h0, 5'd1);
    go('{2'b01, 32'h0, 32'h55, 5'd1, 1'b0, 1'b1});

    ack_at = 2; rdata_val = 32'h0A0B_0C0D;
    set_op(2'b11, 1'b1, 1'b0, 32'h108, 32'h0, 5'd4);
    jump_out = 1'b1; tMux32 = 32'h200;
    #1;
    check("jump_stalled_stall", 32'(stall), 32'h1);
    check("jump_stalled_pcsrc", 32'(PCSrc), 32'h1);
    go('{2'b11, 32'h0A0B_0C0D, 32'h108, 5'd4, 1'b0, 1'b1});
    check("jump_load_stalls", 32'(g_stalls), 32'd2);

    mon_en = 1'b0;
    ack_at = 0;
    set_op(2'b11, 1'b1, 1'b0, 32'h120, 32'h5A5A, 5'd6);
    repeat (3) @(negedge clk);
    check("prerst_req", 32'(dmem_req), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_req", 32'(dmem_req), 32'h0);
    check("midrst_stall", 32'(stall), 32'h0);
    check("midrst_wb3", 32'(Wb3), 32'h0);
    check("midrst_readdata", ReadData, 32'h0);
    check("midrst_aluresout", AluResOut, 32'h0);
    check("midrst_rdout", 32'(rdOut), 32'h0);
    check("midrst_mem_err", 32'(mem_err), 32'h0);
    check("midrst_we", 32'(dmem_we), 32'h0);
    check("midrst_addr", dmem_addr, 32'h0);
    set_op(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    stray_ack = 1'b1;
    @(posedge clk); #2;
    stray_ack = 1'b0;
    check("stray_ack_req", 32'(dmem_req), 32'h0);
    check("stray_ack_readdata", ReadData, 32'h0);
    check("stray_ack_stall", 32'(stall), 32'h0);
    @(posedge clk); #2;

    mon_en = 1'b1;
    set_op(2'b10, 1'b0, 1'b0, 32'h77, 32'h0, 5'd12);
    go('{2'b10, 32'h0, 32'h77, 5'd12, 1'b0, 1'b1});
    mon_en = 1'b0;
    check("sb_drained", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
